// File: rtl/exec_unit_pkg.sv
// Shared types and constants for the execute stage and its iterative mul/div helper.
package exec_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_XOR  = 4'd4,
    OP_SLL  = 4'd5,
    OP_SRL  = 4'd6,
    OP_SRA  = 4'd7,
    OP_MUL  = 4'd8,
    OP_DIVU = 4'd9,
    OP_REMU = 4'd10
  } op_e;

  typedef enum logic [1:0] {
    IDLE,
    ITER,
    WB
  } state_e;

  localparam int          NUM_GPR   = 13;
  localparam logic [31:0] DIV0_QUOT = '1;

  function automatic logic is_muldiv(input op_e op);
    return (op == OP_MUL) || (op == OP_DIVU) || (op == OP_REMU);
  endfunction

endpackage

// File: rtl/exec_unit_if.sv
// Issue handshake plus register-file write port of the execute stage.
interface exec_unit_if #(parameter int WIDTH = 32);
  logic             issue_valid;
  logic             issue_ready;
  logic [3:0]       op;
  logic [3:0]       rd;
  logic [WIDTH-1:0] opA;
  logic [WIDTH-1:0] opB;
  logic [WIDTH-1:0] ALUResult;
  logic [3:0]       WriteReg;
  logic             RegWrite;
  logic             busy;

  modport master (
    output issue_valid, op, rd, opA, opB,
    input  issue_ready, ALUResult, WriteReg, RegWrite, busy
  );

  modport slave (
    input  issue_valid, op, rd, opA, opB,
    output issue_ready, ALUResult, WriteReg, RegWrite, busy
  );
endinterface

// File: rtl/exec_unit_seq_muldiv.sv
// Iterative shift-add multiplier / restoring unsigned divider, one bit per cycle, MSB first.
module seq_muldiv
  import exec_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  op_e              mode_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o
);

  localparam int CW = $clog2(WIDTH);

  logic [WIDTH-1:0] a_q, b_q, q_q, q_d, rem_q, rem_d;
  logic [WIDTH:0]   rem_sh;
  logic [CW-1:0]    cnt_q;
  op_e              mode_q;
  logic             run_q;

  // q_q doubles as the product accumulator (MUL) and the quotient (DIVU/REMU).
  // A zero divisor naturally yields an all-ones quotient and remainder == dividend.
  always_comb begin
    q_d    = q_q;
    rem_d  = rem_q;
    rem_sh = {rem_q, a_q[cnt_q]};
    if (mode_q == OP_MUL) begin
      q_d = {q_q[WIDTH-2:0], 1'b0} + (b_q[cnt_q] ? a_q : '0);
    end else if (rem_sh >= {1'b0, b_q}) begin
      rem_d       = WIDTH'(rem_sh - {1'b0, b_q});
      q_d[cnt_q]  = 1'b1;
    end else begin
      rem_d = rem_sh[WIDTH-1:0];
    end
    result_o = (mode_q == OP_REMU) ? rem_d : q_d;
    done_o   = run_q && (cnt_q == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q    <= '0;
      b_q    <= '0;
      q_q    <= '0;
      rem_q  <= '0;
      cnt_q  <= '0;
      mode_q <= OP_MUL;
      run_q  <= 1'b0;
    end else if (start_i) begin
      a_q    <= a_i;
      b_q    <= b_i;
      q_q    <= '0;
      rem_q  <= '0;
      cnt_q  <= CW'(WIDTH - 1);
      mode_q <= mode_i;
      run_q  <= 1'b1;
    end else if (run_q) begin
      q_q   <= q_d;
      rem_q <= rem_d;
      cnt_q <= cnt_q - 1'b1;
      if (cnt_q == '0) run_q <= 1'b0;
    end
  end

endmodule

// File: rtl/exec_unit.sv
// Execute stage: single-cycle ALU plus optional iterative mul/div, registered writeback.
// Define EXEC_MULDIV_EN to implement MUL/DIVU/REMU; otherwise they are illegal ops.
module exec_unit
  import exec_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int NUM_REGS = NUM_GPR
) (
  input logic        clk,
  input logic        rst,
  exec_unit_if.slave bus
);

  state_e           state_q;
  logic [WIDTH-1:0] alu_q, alu_res, md_result;
  logic [3:0]       wreg_q, pend_rd_q;
  logic             we_q, busy_q, ready_q;
  logic             accept, md_op, sc_legal, md_done;
  op_e              opc;

  assign bus.ALUResult   = alu_q;
  assign bus.WriteReg    = wreg_q;
  assign bus.RegWrite    = we_q;
  assign bus.busy        = busy_q;
  assign bus.issue_ready = ready_q;

  always_comb begin
    opc      = op_e'(bus.op);
    accept   = bus.issue_valid && ready_q;
    sc_legal = (bus.op <= 4'(OP_SRA));
`ifdef EXEC_MULDIV_EN
    md_op    = is_muldiv(opc);
`else
    md_op    = 1'b0;
`endif
    case (opc)
      OP_ADD:  alu_res = bus.opA + bus.opB;
      OP_SUB:  alu_res = bus.opA - bus.opB;
      OP_AND:  alu_res = bus.opA & bus.opB;
      OP_OR:   alu_res = bus.opA | bus.opB;
      OP_XOR:  alu_res = bus.opA ^ bus.opB;
      OP_SLL:  alu_res = bus.opA << bus.opB[4:0];
      OP_SRL:  alu_res = bus.opA >> bus.opB[4:0];
      OP_SRA:  alu_res = WIDTH'($signed(bus.opA) >>> bus.opB[4:0]);
      default: alu_res = '0;
    endcase
  end

`ifdef EXEC_MULDIV_EN
  seq_muldiv #(.WIDTH(WIDTH)) u_muldiv (
    .clk      (clk),
    .rst      (rst),
    .start_i  (accept && md_op),
    .mode_i   (opc),
    .a_i      (bus.opA),
    .b_i      (bus.opB),
    .done_o   (md_done),
    .result_o (md_result)
  );
`else
  assign md_done   = 1'b0;
  assign md_result = '0;
`endif

  // WB accepts exactly like IDLE so single-cycle ops can issue back-to-back.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      alu_q     <= '0;
      wreg_q    <= '0;
      pend_rd_q <= '0;
      we_q      <= 1'b0;
      busy_q    <= 1'b0;
      ready_q   <= 1'b1;
    end else begin
      we_q <= 1'b0;
      case (state_q)
        IDLE, WB: begin
          if (accept && md_op) begin
            state_q   <= ITER;
            busy_q    <= 1'b1;
            ready_q   <= 1'b0;
            pend_rd_q <= bus.rd;
          end else if (accept) begin
            state_q <= WB;
            alu_q   <= alu_res;
            wreg_q  <= bus.rd;
            we_q    <= sc_legal && (32'(bus.rd) < NUM_REGS);
          end else begin
            state_q <= IDLE;
          end
        end
        ITER: begin
          if (md_done) begin
            state_q <= WB;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
            alu_q   <= md_result;
            wreg_q  <= pend_rd_q;
            we_q    <= (32'(pend_rd_q) < NUM_REGS);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_exec_unit.sv
// Randomized bench for exec_unit against a cycle-level behavioural model, plus directed literal checks.
module tb_exec_unit;
  import exec_pkg::*;

  localparam int W = 32;
`ifdef EXEC_MULDIV_EN
  localparam bit MD = 1'b1;
`else
  localparam bit MD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;

  exec_unit_if #(.WIDTH(W)) bus();

  exec_unit #(.WIDTH(W), .NUM_REGS(13)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic bit ref_md(input int op);
    return MD && (op >= 8) && (op <= 10);
  endfunction

  function automatic bit ref_legal(input int op);
    return (op <= 7) || ref_md(op);
  endfunction

  function automatic logic [W-1:0] ref_res(input int op, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [4:0] sh;
    sh = b[4:0];
    if (!ref_legal(op)) return '0;
    case (op)
      0:  return a + b;
      1:  return a - b;
      2:  return a & b;
      3:  return a | b;
      4:  return a ^ b;
      5:  return a << sh;
      6:  return a >> sh;
      7:  return W'($signed(a) >>> sh);
      8:  return a * b;
      9:  return (b == 0) ? '1 : a / b;
      10: return (b == 0) ? a : a % b;
      default: return '0;
    endcase
  endfunction

  typedef struct {
    int             due;
    logic [3:0]     rd;
    logic [W-1:0]   res;
    bit             we;
  } pend_t;

  pend_t        pq[$];
  int           cyc      = 0;
  int           busy_end = 0;
  bit           m_we     = 0;
  bit           m_busy   = 0;
  bit           m_ready  = 1;
  logic [W-1:0] m_alu    = '0;
  logic [3:0]   m_wreg   = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      pq.delete();
      busy_end = cyc;
      m_we     = 0;
      m_busy   = 0;
      m_ready  = 1;
      m_alu    = '0;
      m_wreg   = '0;
    end else begin
      int op;
      cyc++;
      m_we = 0;
      if (pq.size() > 0 && pq[0].due == cyc) begin
        m_we   = pq[0].we;
        m_alu  = pq[0].res;
        m_wreg = pq[0].rd;
        void'(pq.pop_front());
      end
      if (bus.issue_valid && m_ready) begin
        op = int'(bus.op);
        if (ref_md(op)) begin
          pq.push_back('{due: cyc + W, rd: bus.rd, res: ref_res(op, bus.opA, bus.opB),
                         we: (bus.rd < 4'd13)});
          busy_end = cyc + W;
        end else begin
          m_we   = ref_legal(op) && (bus.rd < 4'd13);
          m_alu  = ref_res(op, bus.opA, bus.opB);
          m_wreg = bus.rd;
        end
      end
      m_busy  = cyc < busy_end;
      m_ready = !m_busy;
    end
  end

  always @(negedge clk) begin
    chk("RegWrite",    bus.RegWrite,    m_we);
    chk("issue_ready", bus.issue_ready, m_ready);
    chk("busy",        bus.busy,        m_busy);
    chk("ALUResult",   bus.ALUResult,   m_alu);
    chk("WriteReg",    bus.WriteReg,    m_wreg);
  end

  // ---------------- drivers ----------------
  task automatic send(input int op, input int rd, input logic [W-1:0] a, input logic [W-1:0] b);
    int g = 0;
    while (!bus.issue_ready && g < 100) begin
      @(posedge clk); #1;
      g++;
    end
    if (g >= 100) chk("ready_timeout", bus.issue_ready, 1);
    bus.issue_valid = 1'b1;
    bus.op  = 4'(op);
    bus.rd  = 4'(rd);
    bus.opA = a;
    bus.opB = b;
    @(posedge clk); #1;
    bus.issue_valid = 1'b0;
    bus.op  = 4'($urandom);
    bus.rd  = 4'($urandom);
    bus.opA = $urandom;
    bus.opB = $urandom;
  endtask

  // lat counts edges from acceptance to the edge that ends the write cycle
  task automatic wait_wb(output logic [W-1:0] res, output logic [3:0] wr, output int lat, output int low);
    lat = 0;
    low = 0;
    do begin
      @(negedge clk);
      lat++;
      if (!bus.issue_ready) low++;
    end while (!bus.RegWrite && lat < 60);
    res = bus.ALUResult;
    wr  = bus.WriteReg;
  endtask

  initial begin
    logic [W-1:0] res;
    logic [3:0]   wr;
    int           lat, low, seen;

    bus.issue_valid = 1'b0;
    bus.op  = '0;
    bus.rd  = '0;
    bus.opA = '0;
    bus.opB = '0;

    // model pins
    chk("model_add_wrap", ref_res(0, 32'hFFFF_FFFF, 32'd2), 32'h0000_0001);
    chk("model_sra",      ref_res(7, 32'h8000_0000, 32'd4), 32'hF800_0000);
    chk("model_illegal",  ref_res(14, 32'd5, 32'd6), 32'd0);

    repeat (3) @(negedge clk);
    chk("rst_ALUResult", bus.ALUResult, 0);
    chk("rst_WriteReg",  bus.WriteReg, 0);
    chk("rst_RegWrite",  bus.RegWrite, 0);
    chk("rst_busy",      bus.busy, 0);
    chk("rst_ready",     bus.issue_ready, 1);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // ADD wrap
    send(0, 3, 32'hFFFF_FFFF, 32'd2);
    @(negedge clk);
    chk("add_we",  bus.RegWrite, 1);
    chk("add_rd",  bus.WriteReg, 3);
    chk("add_res", bus.ALUResult, 32'h0000_0001);
    @(negedge clk);
    chk("add_we_drop", bus.RegWrite, 0);
    @(posedge clk); #1;

    // back-to-back SUB then SRA
    fork
      begin
        send(1, 1, 32'd5, 32'd7);
        send(7, 2, 32'h8000_0000, 32'd4);
      end
      begin
        @(posedge clk);
        @(negedge clk);
        chk("b2b_sub_we",  bus.RegWrite, 1);
        chk("b2b_sub_res", bus.ALUResult, 32'hFFFF_FFFE);
        @(negedge clk);
        chk("b2b_sra_we",  bus.RegWrite, 1);
        chk("b2b_sra_rd",  bus.WriteReg, 2);
        chk("b2b_sra_res", bus.ALUResult, 32'hF800_0000);
      end
    join
    @(posedge clk); #1;

    // illegal destination / opcode
    send(0, 13, 32'd1, 32'd2);
    @(negedge clk);
    chk("rd13_we",    bus.RegWrite, 0);
    chk("rd13_ready", bus.issue_ready, 1);
    @(posedge clk); #1;
    send(14, 0, 32'd1, 32'd2);
    @(negedge clk);
    chk("op14_we",    bus.RegWrite, 0);
    chk("op14_ready", bus.issue_ready, 1);
    chk("op14_res",   bus.ALUResult, 0);
    @(posedge clk); #1;

    if (MD) begin
      send(8, 12, 32'h0001_0001, 32'h0001_0001);
      wait_wb(res, wr, lat, low);
      chk("mul_res", res, 32'h0002_0001);
      chk("mul_rd",  wr, 12);
      chk("mul_lat", lat, 33);
      chk("mul_low", low, 32);
      @(posedge clk); #1;
      send(9, 4, 32'd100, 32'd7);
      wait_wb(res, wr, lat, low);
      chk("divu_res", res, 14);
      send(10, 4, 32'd100, 32'd7);
      wait_wb(res, wr, lat, low);
      chk("remu_res", res, 2);
      send(9, 5, 32'd9, 32'd0);
      wait_wb(res, wr, lat, low);
      chk("divu0_res", res, 32'hFFFF_FFFF);
      chk("divu0_lat", lat, 33);
      send(10, 5, 32'd9, 32'd0);
      wait_wb(res, wr, lat, low);
      chk("remu0_res", res, 9);
      @(posedge clk); #1;
    end else begin
      send(8, 12, 32'h0001_0001, 32'h0001_0001);
      @(negedge clk);
      chk("mul_off_we",    bus.RegWrite, 0);
      chk("mul_off_busy",  bus.busy, 0);
      chk("mul_off_ready", bus.issue_ready, 1);
      @(posedge clk); #1;
    end

    // reset in the middle of a divide
    send(9, 6, 32'd1000, 32'd3);
    repeat (9) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abort_busy",  bus.busy, 0);
    chk("abort_ready", bus.issue_ready, 1);
    chk("abort_we",    bus.RegWrite, 0);
    chk("abort_res",   bus.ALUResult, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.RegWrite) seen++;
    end
    chk("abort_no_wb", seen, 0);
    @(posedge clk); #1;
    send(0, 5, 32'd10, 32'd20);
    @(negedge clk);
    chk("post_rst_we",  bus.RegWrite, 1);
    chk("post_rst_res", bus.ALUResult, 30);
    @(posedge clk); #1;

    // randomized traffic, checked by the model every cycle
    repeat (250) begin
      int op, rd;
      logic [W-1:0] a, b;
      op = (($urandom % 4) == 0) ? int'($urandom_range(8, 15)) : int'($urandom_range(0, 7));
      rd = int'($urandom_range(0, 15));
      a  = (($urandom % 4) == 0) ? W'($urandom_range(0, 300)) : W'($urandom);
      case ($urandom % 6)
        0:       b = '0;
        1:       b = W'($urandom_range(1, 20));
        default: b = W'($urandom);
      endcase
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
      send(op, rd, a, b);
    end

    repeat (40) @(posedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
